multdiv: RTL
============

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ctrl_MULT  in  1  one-cycle start pulse, signed multiply.
REQ-004 SHALL have ports: ctrl_DIV  in  1  one-cycle start pulse, signed divide.
REQ-005 SHALL have ports: data_operandA  in  32  multiplicand / dividend, two's complement.
REQ-006 SHALL have ports: data_operandB  in  32  multiplier / divisor, two's complement.
REQ-007 SHALL have ports: data_result  out  32  product low word / quotient.
REQ-008 SHALL have ports: data_exception  out  1  overflow or divide-by-zero flag, valid with result.
REQ-009 SHALL have ports: data_resultRDY  out  1  one-cycle result-valid strobe.
REQ-010 SHALL have parameters: none; iteration counts are fixed constants.

Function
REQ-011 SHALL sample operands only on the clock edge where a ctrl pulse is high (start edge, E0); operand changes afterwards SHALL be ignored.
REQ-012 SHALL use states IDLE, MULT, DIV, DONE; IDLE->MULT on ctrl_MULT, IDLE->DIV on ctrl_DIV, MULT/DIV->DONE when the iteration counter expires, DONE->IDLE next edge.
REQ-013 If ctrl_MULT and ctrl_DIV are both high, multiply SHALL win.
REQ-014 Multiply SHALL be radix-4 Booth, 16 iterations over a 66-bit product register; data_resultRDY SHALL be high for exactly the one cycle after edge E0+17.
REQ-015 Divide SHALL be non-restoring on magnitudes, 32 iterations plus sign fix-up; data_resultRDY SHALL be high for exactly the one cycle after edge E0+33.
REQ-016 Multiply result SHALL be product[31:0]; data_exception SHALL be 1 iff product[63:32] is not the sign extension of product[31].
REQ-017 Quotient SHALL truncate toward zero; remainder is discarded.
REQ-018 Divisor 0: result 32'h00000000, data_exception 1, same latency as normal divide.
REQ-019 32'h80000000 / -1: result 32'h80000000, data_exception 1.
REQ-020 A new ctrl pulse in any state SHALL abandon the current operation without a resultRDY strobe and restart per REQ-011.
REQ-021 data_result and data_exception SHALL hold their last values after the strobe until the next completion or reset.
REQ-022 data_resultRDY SHALL never be high for two consecutive cycles.

Reset
REQ-023 reset high at an edge SHALL force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, discarding any operation in flight.
REQ-024 reset SHALL take priority over ctrl_MULT and ctrl_DIV sampled on the same edge.

Structure
REQ-025 State encodings, iteration counts (16, 32) and the 32'h80000000 constant SHALL live in a shared constants file used by RTL and bench.
REQ-026 The one-iteration add/subtract-and-shift step of the divider SHALL be one combinational sub-module, div_step; the Booth datapath, counter and FSM SHALL stay in multdiv.

Verification
REQ-027 Pulse ctrl_MULT with A=7, B=-6 -> single RDY after E0+17, result 32'hFFFFFFD6, exception 0.
REQ-028 Pulse ctrl_MULT with A=32'h00010000, B=32'h00010000 -> result 32'h00000000, exception 1.
REQ-029 Pulse ctrl_DIV with A=-7, B=2 -> single RDY after E0+33, result 32'hFFFFFFFD, exception 0; with A=5, B=0 -> result 0, exception 1.
REQ-030 Pulse ctrl_DIV with A=32'h80000000, B=32'hFFFFFFFF -> result 32'h80000000, exception 1.
REQ-031 Start multiply 7*6, pulse ctrl_DIV 100/7 at E0+8 -> no RDY for the multiply; one RDY 33 cycles after the second pulse, result 14.
REQ-032 Start multiply 3*3, assert reset at E0+5 for one cycle -> RDY stays 0 for 40 cycles, result 0, exception 0.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_pkg
//  Brief    : Shared state encodings, iteration counts and constants for
//             the multdiv multiply/divide unit and its bench.
//  Revision : 1.0  initial release
// ============================================================================
package multdiv_pkg;

  localparam int          c_STATE_W    = 2;
  localparam logic [1:0]  c_ST_IDLE    = 2'd0;
  localparam logic [1:0]  c_ST_MULT    = 2'd1;
  localparam logic [1:0]  c_ST_DIV     = 2'd2;
  localparam logic [1:0]  c_ST_DONE    = 2'd3;

  localparam int          c_CNT_W      = 6;
  localparam int          c_MULT_ITERS = 16;
  localparam int          c_DIV_ITERS  = 32;
  localparam logic [5:0]  c_MULT_LAST  = 6'(c_MULT_ITERS - 1);
  localparam logic [5:0]  c_DIV_LAST   = 6'(c_DIV_ITERS - 1);

  localparam logic [31:0] c_INT_MIN    = 32'h8000_0000;

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Brief    : One non-restoring divide iteration on magnitudes: shift the
//             partial remainder, add or subtract the divisor, emit a quotient bit.
//  Revision : 1.0  initial release
// ============================================================================
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] w_shifted;
  logic [32:0] w_dvsr;

  // Remainder stays within [-D, D), so dropping rem_i[32] on the shift is lossless.
  always_comb begin
    w_shifted = {rem_i[31:0], quo_i[31]};
    w_dvsr    = {1'b0, divisor_i};
    rem_o     = rem_i[32] ? (w_shifted + w_dvsr) : (w_shifted - w_dvsr);
    quo_o     = {quo_i[30:0], ~rem_o[32]};
  end

endmodule : div_step
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv
//  Brief    : Iterative signed 32-bit multiplier (radix-4 Booth) and divider
//             (non-restoring) with a single result-valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module multdiv
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  logic [c_STATE_W-1:0] state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q;
  logic                 is_mult_q;

  logic [65:0]          prod_q;
  logic [31:0]          mcand_q;

  logic [32:0]          rem_q;
  logic [31:0]          quo_q;
  logic [31:0]          dvsr_q;
  logic                 neg_q;
  logic                 dvz_q;
  logic                 dovf_q;

  logic [31:0]          result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  logic                 w_start;
  logic [33:0]          w_a34;
  logic [33:0]          w_addend;
  logic [33:0]          w_upper_sum;
  logic [65:0]          w_prod_next;
  logic [63:0]          w_product;
  logic                 w_mul_ovf;
  logic [31:0]          w_abs_a;
  logic [31:0]          w_abs_b;
  logic [32:0]          w_rem_next;
  logic [31:0]          w_quo_next;
  logic [31:0]          w_quo_signed;

  assign w_start = ctrl_MULT | ctrl_DIV;

  // Booth datapath: prod_q = {upper[32:0], multiplier[31:0], q_-1}
  always_comb begin
    w_a34 = {{2{mcand_q[31]}}, mcand_q};
    unique case (prod_q[2:0])
      3'b001, 3'b010: w_addend = w_a34;
      3'b011:         w_addend = w_a34 << 1;
      3'b100:         w_addend = 34'd0 - (w_a34 << 1);
      3'b101, 3'b110: w_addend = 34'd0 - w_a34;
      default:        w_addend = 34'd0;
    endcase
    w_upper_sum = {prod_q[65], prod_q[65:33]} + w_addend;
    w_prod_next = {w_upper_sum[33], w_upper_sum, prod_q[32:2]};
    w_product   = prod_q[64:1];
    w_mul_ovf   = (w_product[63:32] != {32{w_product[31]}});
  end

  always_comb begin
    w_abs_a      = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    w_abs_b      = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
    w_quo_signed = neg_q ? (32'd0 - quo_q) : quo_q;
  end

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (w_rem_next),
    .quo_o     (w_quo_next)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= c_ST_IDLE;
    else       state_q <= state_d;
  end

  // Any start pulse restarts from scratch, whatever the current state.
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = c_ST_MULT;
    end else if (ctrl_DIV) begin
      state_d = c_ST_DIV;
    end else begin
      unique case (state_q)
        c_ST_MULT: if (cnt_q == c_MULT_LAST) state_d = c_ST_DONE;
        c_ST_DIV:  if (cnt_q == c_DIV_LAST)  state_d = c_ST_DONE;
        c_ST_DONE: state_d = c_ST_IDLE;
        default:   state_d = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy_d    = 1'b0;
    result_d = result_q;
    exc_d    = exc_q;
    if (state_q == c_ST_DONE && !w_start) begin
      rdy_d = 1'b1;
      if (is_mult_q) begin
        result_d = w_product[31:0];
        exc_d    = w_mul_ovf;
      end else if (dvz_q) begin
        result_d = 32'd0;
        exc_d    = 1'b1;
      end else begin
        result_d = w_quo_signed;
        exc_d    = dovf_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      is_mult_q <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q     <= 1'b0;
      dvz_q     <= 1'b0;
      dovf_q    <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      if (ctrl_MULT) begin
        cnt_q     <= '0;
        is_mult_q <= 1'b1;
        prod_q    <= {33'd0, data_operandB, 1'b0};
        mcand_q   <= data_operandA;
      end else if (ctrl_DIV) begin
        cnt_q     <= '0;
        is_mult_q <= 1'b0;
        rem_q     <= '0;
        quo_q     <= w_abs_a;
        dvsr_q    <= w_abs_b;
        neg_q     <= data_operandA[31] ^ data_operandB[31];
        dvz_q     <= (data_operandB == 32'd0);
        dovf_q    <= (data_operandA == c_INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
      end else if (state_q == c_ST_MULT) begin
        cnt_q  <= cnt_q + 1'b1;
        prod_q <= w_prod_next;
      end else if (state_q == c_ST_DIV) begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= w_rem_next;
        quo_q <= w_quo_next;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule : multdiv
`default_nettype wire
